// File: rtl/fc_score_acc.sv
// fc_score_acc: fully-connected layer score accumulator.
// Accumulates N_IN signed 16x16 products per class and emits N_CLASS
// class scores per frame, in class order, each with a one-cycle score_en
// strobe, followed by a one-cycle done pulse.
// Optional build macro FC_SCORE_SAT_EN: saturating accumulation instead
// of two's-complement wrap.
`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module fc_score_acc #(
  parameter int unsigned N_IN    = 64,
  parameter int unsigned N_CLASS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               act_in,
  input  logic [15:0]               weight_in,
  output logic [`INTERNAL_BITS-1:0] score_out,
  output logic                      score_en,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned AW = `INTERNAL_BITS;
  localparam int unsigned PW = (N_IN    > 1) ? $clog2(N_IN)    : 1;
  localparam int unsigned CW = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    EMIT = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [AW-1:0]   score_q, score_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [CW-1:0]   class_q, class_d;

  logic signed [31:0] prod;
  logic [AW-1:0]      prod_ext;
  logic [AW-1:0]      sum_wrap;
  logic [AW-1:0]      acc_next;
  logic               ovf;

  assign prod     = $signed(act_in) * $signed(weight_in);
  assign prod_ext = AW'(prod);
  assign sum_wrap = acc_q + prod_ext;
  // Signed overflow: operands share a sign that the wrapped result lacks.
  assign ovf      = (acc_q[AW-1] == prod_ext[AW-1]) && (sum_wrap[AW-1] != acc_q[AW-1]);

  // Accumulate step: saturate on overflow when enabled, otherwise wrap.
  always_comb begin
    acc_next = sum_wrap;
`ifdef FC_SCORE_SAT_EN
    if (ovf) begin
      acc_next = acc_q[AW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
`else
    if (ovf) begin
      acc_next = sum_wrap;
    end
`endif
  end

  // State, accumulator, counters and score register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      score_q <= '0;
      pair_q  <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      pair_q  <= pair_d;
      class_q <= class_d;
    end
  end

  // Next-state and datapath control.
  // The final sum is captured into score_q on the last acceptance so that
  // score_out already holds it during EMIT; EMIT then clears for the next class.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    score_d = score_q;
    pair_d  = pair_q;
    class_d = class_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          pair_d  = '0;
          class_d = '0;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = acc_next;
          if (pair_q == PW'(N_IN - 1)) begin
            score_d = acc_next;
            state_d = EMIT;
          end else begin
            pair_d = pair_q + 1'b1;
          end
        end
      end
      EMIT: begin
        acc_d   = '0;
        pair_d  = '0;
        class_d = class_q + 1'b1;
        if (class_q < CW'(N_CLASS - 1)) begin
          state_d = ACC;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ACC);
  assign score_en  = (state_q == EMIT);
  assign done      = (state_q == FIN);
  assign busy      = (state_q != IDLE);
  assign score_out = score_q;

endmodule
